// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch/decode path: field layout, register
// codes, load modes, opcode constants and the fetch sequencer states.
package cpu_isa_pkg;

  localparam int ADDR_SIZE   = 8;
  localparam int WORD_SIZE   = 16;

  localparam int OPERAND_LSB = 0;
  localparam int OPERAND_W   = 8;
  localparam int OP_LSB      = 8;
  localparam int OP_W        = 3;
  localparam int OPCODE_LSB  = 11;
  localparam int OPCODE_W    = WORD_SIZE - OPCODE_LSB;

  typedef enum logic [3:0] {
    REG_A        = 4'd0,
    REG_B        = 4'd1,
    REG_DATA_OUT = 4'd2,
    REG_INST_REG = 4'd3,
    REG_ADDR_REG = 4'd4,
    REG_GPREG    = 4'd5
  } reg_code_t;

  typedef enum logic [1:0] {
    LD_CONSTANT = 2'd0,
    LD_MEMORY   = 2'd1,
    LD_POINTER  = 2'd2
  } ld_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ISSUE,
    ST_HALT
  } fetch_state_t;

  localparam logic [OPCODE_W-1:0] OPC_NOP  = 5'd0;
  localparam logic [OPCODE_W-1:0] OPC_LOAD = 5'd1;
  localparam logic [OPCODE_W-1:0] OPC_STO  = 5'd2;
  localparam logic [OPCODE_W-1:0] OPC_MOV  = 5'd3;
  localparam logic [OPCODE_W-1:0] OPC_ADD  = 5'd4;
  localparam logic [OPCODE_W-1:0] OPC_SUB  = 5'd5;
  localparam logic [OPCODE_W-1:0] OPC_JMP  = 5'd6;
  localparam logic [OPCODE_W-1:0] OPC_HALT = 5'd7;
  // Opcodes are allocated densely, so anything above the last one is outside the ISA.
  localparam logic [OPCODE_W-1:0] OPC_LAST = OPC_HALT;

  function automatic logic is_reg_code(input logic [3:0] code);
    return code <= REG_GPREG;
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational split of an instruction word into ISA fields, plus the
// legality check of those fields against the opcode.
module inst_field_decode
  import cpu_isa_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE
) (
  input  logic [WORD_W-1:0]  ir,
  output logic [WORD_W-12:0] opcode,
  output logic               ld_reg,
  output logic [1:0]         ld_mode,
  output logic [2:0]         sto_src,
  output logic [3:0]         mov_src,
  output logic [3:0]         mov_dst,
  output logic [7:0]         operand,
  output logic               illegal
);

  localparam int OPC_W = WORD_W - OPCODE_LSB;

  logic [OP_W-1:0] op;

  assign opcode  = ir[WORD_W-1:OPCODE_LSB];
  assign op      = ir[OP_LSB +: OP_W];
  assign operand = ir[OPERAND_LSB +: OPERAND_W];
  assign ld_reg  = op[2];
  assign ld_mode = op[1:0];
  assign sto_src = op;
  assign mov_src = operand[7:4];
  assign mov_dst = operand[3:0];

  always_comb begin
    illegal = 1'b0;
    if (opcode > OPC_W'(OPC_LAST)) begin
      illegal = 1'b1;
    end else if (opcode == OPC_W'(OPC_LOAD)) begin
      illegal = (ld_mode > LD_POINTER);
    end else if (opcode == OPC_W'(OPC_STO)) begin
      illegal = !is_reg_code({1'b0, sto_src});
    end else if (opcode == OPC_W'(OPC_MOV)) begin
      illegal = !is_reg_code(mov_src) || !is_reg_code(mov_dst);
    end
  end

endmodule

// File: rtl/inst_fetch_decode.sv
// Program-ROM reader: sequences fetch addresses, captures the word into the
// instruction register and issues decoded fields over a valid/ready handshake.
module inst_fetch_decode
  import cpu_isa_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_SIZE,
  parameter int                WORD_W   = WORD_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'('hFE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               boot,
  output logic [ADDR_W-1:0]  addr,
  input  logic [WORD_W-1:0]  data,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_target,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [WORD_W-12:0] opcode,
  output logic               ld_reg,
  output logic [1:0]         ld_mode,
  output logic [2:0]         sto_src,
  output logic [3:0]         mov_src,
  output logic [3:0]         mov_dst,
  output logic [7:0]         operand,
  output logic               illegal,
  output logic               halted
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [WORD_W-1:0] ir_reg, ir_next;
  logic              illegal_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE: begin
        if (boot) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (boot) begin
          ir_next    = data;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (inst_ready) begin
          if (pc_reg == END_ADDR) begin
            state_next = ST_HALT;
          end else begin
            pc_next    = pc_reg + ADDR_W'(2);
            state_next = boot ? ST_ADDR : ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
    // A redirect overrides everything, including a same-cycle acceptance.
    if (pc_load) begin
      pc_next    = pc_target & ~ADDR_W'(1);
      ir_next    = '0;
      state_next = boot ? ST_ADDR : ST_IDLE;
    end
  end

  assign addr       = pc_reg;
  assign inst_valid = (state_reg == ST_ISSUE);
  assign halted     = (state_reg == ST_HALT);
  assign illegal    = illegal_raw & inst_valid;

  inst_field_decode #(
    .WORD_W (WORD_W)
  ) u_decode (
    .ir      (ir_reg),
    .opcode  (opcode),
    .ld_reg  (ld_reg),
    .ld_mode (ld_mode),
    .sto_src (sto_src),
    .mov_src (mov_src),
    .mov_dst (mov_dst),
    .operand (operand),
    .illegal (illegal_raw)
  );

endmodule
